// File: rtl/am9513_legacy_stack.sv
// am9513_legacy_stack
// Operand stack behind the legacy 9511/9512 compatibility shell. It serves the
// shell's pop/push strobes and a host-side CSR port that pushes 64-bit operands
// as two 32-bit halves, pops results and clears the stack. Sticky overflow and
// underflow flags report misuse.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   stack_pop_we, stack_push_we   shell strobes
//   stack_push_data[63:0]         shell push value
//   stack_depth, stack_empty,     occupancy status (registered state)
//   stack_full
//   stack_top[63:0]               combinational top entry, 0 when empty
//   shell_busy                    host ops rejected while high
//   host_push_lo_we               stage host_wdata as low half
//   host_push_hi_we               push {host_wdata, low half}
//   host_wdata[31:0]              host write data
//   host_pop_re                   pop top into host_rdata
//   host_rdata[63:0], host_rvalid registered pop result + 1-cycle pulse
//   host_clear                    empty stack, clear flags and staging
//   host_reject                   1-cycle pulse for a refused host op
//   err_overflow, err_underflow   sticky error flags
//
// Build option:
//   AM9513_LEGACY_STACK_WRAP_EN   when defined, a push on full overwrites the
//                                 oldest entry (circular 9511 behaviour);
//                                 otherwise the push is dropped.

module am9513_legacy_stack #(
  parameter int LEGACY_STACK_DEPTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  stack_pop_we,
  input  logic                                  stack_push_we,
  input  logic [63:0]                           stack_push_data,
  output logic [$clog2(LEGACY_STACK_DEPTH+1)-1:0] stack_depth,
  output logic                                  stack_empty,
  output logic                                  stack_full,
  output logic [63:0]                           stack_top,
  input  logic                                  shell_busy,
  input  logic                                  host_push_lo_we,
  input  logic                                  host_push_hi_we,
  input  logic [31:0]                           host_wdata,
  input  logic                                  host_pop_re,
  output logic [63:0]                           host_rdata,
  output logic                                  host_rvalid,
  input  logic                                  host_clear,
  output logic                                  host_reject,
  output logic                                  err_overflow,
  output logic                                  err_underflow
);

  localparam int D  = LEGACY_STACK_DEPTH;
  localparam int DW = $clog2(D+1);
  localparam int PW = $clog2(D);

  logic [63:0]   mem [D];
  logic [PW-1:0] tp, tp_nxt, tp_inc, tp_dec, wr_idx;
  logic [DW-1:0] depth, depth_nxt;
  logic [31:0]   stage;
  logic          wr_en;
  logic [63:0]   push_val;
  logic          push_req, pop_req, host_pop_req, host_acc, reject_nxt;
  logic          ovf_set, unf_set, rvalid_nxt;
  logic          shell_any, host_any;

  assign shell_any = stack_pop_we | stack_push_we;
  assign host_any  = host_push_lo_we | host_push_hi_we | host_pop_re;

  // Explicit wrap so non-power-of-two depths work.
  assign tp_inc = (tp == PW'(D-1)) ? '0 : tp + PW'(1);
  assign tp_dec = (tp == '0) ? PW'(D-1) : tp - PW'(1);

  assign stack_depth = depth;
  assign stack_empty = (depth == '0);
  assign stack_full  = (depth == DW'(D));
  assign stack_top   = stack_empty ? 64'h0 : mem[tp];

  // Arbitration: clear wins over everything, shell strobes win over host ops.
  // Any host op coinciding with a shell strobe or shell_busy is refused whole.
  always_comb begin
    push_req     = 1'b0;
    pop_req      = 1'b0;
    host_pop_req = 1'b0;
    host_acc     = 1'b0;
    reject_nxt   = 1'b0;
    push_val     = stack_push_data;
    if (!host_clear) begin
      if (shell_any) begin
        push_req   = stack_push_we;
        pop_req    = stack_pop_we;
        reject_nxt = host_any;
      end else if (host_any) begin
        if (shell_busy || (host_push_hi_we && host_pop_re)) begin
          reject_nxt = 1'b1;
        end else begin
          host_acc     = 1'b1;
          push_req     = host_push_hi_we;
          pop_req      = host_pop_re;
          host_pop_req = host_pop_re;
          // lo+hi together: the new word forms both halves
          push_val     = {host_wdata, host_push_lo_we ? host_wdata : stage};
        end
      end
    end
  end

  // Stack pointer / depth update for the winning request.
  always_comb begin
    tp_nxt    = tp;
    depth_nxt = depth;
    wr_en     = 1'b0;
    wr_idx    = tp_inc;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (push_req && pop_req) begin
      wr_en = 1'b1;
      if (stack_empty) begin
        // replace on empty degenerates to a plain push
        tp_nxt    = tp_inc;
        depth_nxt = DW'(1);
      end else begin
        wr_idx = tp;
      end
    end else if (push_req) begin
      if (stack_full) begin
        ovf_set = 1'b1;
`ifdef AM9513_LEGACY_STACK_WRAP_EN
        // overwrite oldest entry; depth stays at D
        wr_en  = 1'b1;
        tp_nxt = tp_inc;
`else
        wr_en  = 1'b0;
`endif
      end else begin
        wr_en     = 1'b1;
        tp_nxt    = tp_inc;
        depth_nxt = depth + DW'(1);
      end
    end else if (pop_req) begin
      if (stack_empty) begin
        unf_set = 1'b1;
      end else begin
        tp_nxt    = tp_dec;
        depth_nxt = depth - DW'(1);
      end
    end
  end

  assign rvalid_nxt = host_pop_req && !stack_empty;

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp            <= '0;
      depth         <= '0;
      stage         <= '0;
      host_rdata    <= '0;
      host_rvalid   <= 1'b0;
      host_reject   <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (host_clear) begin
      tp            <= '0;
      depth         <= '0;
      stage         <= '0;
      host_rvalid   <= 1'b0;
      host_reject   <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      tp          <= tp_nxt;
      depth       <= depth_nxt;
      host_rvalid <= rvalid_nxt;
      host_reject <= reject_nxt;
      if (host_acc && host_push_lo_we) stage <= host_wdata;
      if (rvalid_nxt) host_rdata <= mem[tp];
      if (ovf_set) err_overflow  <= 1'b1;
      if (unf_set) err_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/am9513_legacy_stack.md
# am9513_legacy_stack

Operand stack for the Am9513 legacy 9511/9512 compatibility path. It is the responder side of the legacy shell's stack interface: it serves pop/push strobes from the shell, and exposes depth, empty, full and top. A host-side port lets CSR logic push 64-bit operands as two 32-bit halves, pop results, and clear the stack. Sticky overflow and underflow flags report misuse.

## Interface
- `LEGACY_STACK_DEPTH`, 16: number of 64-bit entries. Must be ≥ 2; need not be a power of two.
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stack_pop_we` in 1: shell pop strobe.
- `stack_push_we` in 1: shell push strobe.
- `stack_push_data` in 64: shell push value.
- `stack_depth` out $clog2(LEGACY_STACK_DEPTH+1): current entry count.
- `stack_empty` out 1: depth == 0.
- `stack_full` out 1: depth == LEGACY_STACK_DEPTH.
- `stack_top` out 64: top entry; 64'h0 when empty.
- `shell_busy` in 1: shell sequence active; host operations are rejected while high.
- `host_push_lo_we` in 1: latch `host_wdata` into the low-half staging register.
- `host_push_hi_we` in 1: push {`host_wdata`, staged low half}.
- `host_wdata` in 32: host write data.
- `host_pop_re` in 1: pop top into `host_rdata`.
- `host_rdata` out 64: last host-popped value, registered.
- `host_rvalid` out 1: one-cycle pulse, the cycle after an accepted host pop.
- `host_clear` in 1: empty the stack and clear the sticky flags.
- `host_reject` out 1: one-cycle pulse when a host operation is refused.
- `err_overflow` out 1: sticky; set by a push that was dropped or that overwrote an entry.
- `err_underflow` out 1: sticky; set by a pop on an empty stack.

## Operation
**Storage.** Circular buffer with top pointer `tp` (index of the top entry) and count `depth`.
- Push: `tp` ← (`tp`+1) mod D, then write `mem[tp]`.
- Pop: `tp` ← (`tp`−1) mod D. Wrap is computed explicitly; no power-of-two mask.

**Event priority per cycle.** `host_clear` > shell ops > host ops.
- `host_clear`: `depth`=0, `tp`=0, both sticky flags cleared, staging register cleared. Every other request in that cycle is ignored, with no reject pulse.
- Shell push and pop in the same cycle: replace. `mem[tp]` ← push data; `depth` and `tp` are unchanged. If empty, this acts as a plain push.
- Shell pop on empty: no state change; `err_underflow` set.
- Shell push on full: governed by the Configuration section.

**Host operations.** Host ops are accepted only when `shell_busy`=0 and no shell strobe is active in the same cycle. Otherwise `host_reject` pulses the next cycle and no state changes, including the staging register.
- `host_push_hi_we` and `host_pop_re` in the same cycle: both are rejected.
- `host_push_lo_we` together with `host_push_hi_we`: the new `host_wdata` forms both halves.
- Accepted host pop on empty: `err_underflow` set, `host_rdata` unchanged, no `host_rvalid`.

**Reset values.** `depth`=0, `stack_empty`=1, `stack_full`=0, `stack_top`=0, `host_rdata`=0, `host_rvalid`=0, `host_reject`=0, both flags=0, staging=0. `mem` is not reset. Reset mid-sequence discards all state.

## Timing
- All strobes are sampled at a rising edge. `depth`, `empty`, `full` and `top` reflect the result from the following cycle.
- `stack_top` is combinational from `mem[tp]` and `depth`. Back-to-back shell pops on consecutive cycles therefore each see a fresh top: the shell samples `top` in the same cycle it asserts pop, and the pop takes effect at that edge.
- Host pop: `host_rdata` and `host_rvalid` are updated at the edge after the accepted strobe, giving 1-cycle latency.
- No throughput limit: one operation per cycle on either side.

## Configuration
- `AM9513_LEGACY_STACK_WRAP_EN` defined: 9511-style circular stack. A push on full advances `tp` and overwrites the oldest entry. `depth` stays at D and `err_overflow` is set.
- `AM9513_LEGACY_STACK_WRAP_EN` undefined: a push on full is dropped. `tp`, `depth` and `mem` are unchanged and `err_overflow` is set.
- The replace case (push and pop together) never sets overflow in either mode.

## Test plan
- After reset, host pushes lo=32'h0000_0000 and hi=32'h3FF0_0000 (1.0 in fp64). Expect `depth`=1, `top`=64'h3FF0_0000_0000_0000, `empty`=0.
- Host pushes 3 values, then 3 shell pops on consecutive cycles. Expect `top` sampled in each pop cycle to equal the values in reverse push order, then `depth`=0 and `top`=0.
- Fill to 16, then shell push 64'hAA. With WRAP_EN: `depth`=16, `top`=64'hAA, the first pushed value is lost, and `err_overflow`=1. Without WRAP_EN: `top` is unchanged and `err_overflow`=1.
- Empty stack, shell pop. Expect `err_underflow`=1 and `depth`=0. Then `host_clear` clears both flags.
- Host pop with `shell_busy`=1. Expect `host_reject` pulse, `depth` unchanged, no `host_rvalid`. Repeat with `shell_busy`=0: `host_rvalid` pulses one cycle later with the old top.
- Depth 5, shell push 64'h55 and pop in the same cycle. Expect `depth`=5, `top`=64'h55, no error flags.
